// File: rtl/rot_scheduler_pkg.sv
// rtl/rot_scheduler_pkg.sv - shared types and constants for the rotate scheduler
// Holds the FSM state encoding, the requester source encoding and the
// datapath widths used by the interface, the scheduler and the bench.
package rot_scheduler_pkg;

  localparam int DATA_W      = 8;
  localparam int AMT_W       = 3;
  localparam int SWEEP_STEPS = 8;

  // Wide enough to hold a full sweep count (0..SWEEP_STEPS).
  localparam int CNT_W = $clog2(SWEEP_STEPS + 1);

  localparam logic [CNT_W-1:0] SWEEP_CNT = CNT_W'(SWEEP_STEPS);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/rot_scheduler_if.sv
// rtl/rot_scheduler_if.sv - request and result handshake bundle for rot_scheduler
// Requester A : a_valid, a_ready, a_data, a_amt, a_sweep
// Requester B : b_valid, b_ready, b_data, b_amt, b_sweep
// Result      : out_valid, out_ready, out_data, out_src (0 = A, 1 = B), out_last
// master = requesters + consumer side, slave = scheduler side.
interface rot_scheduler_if;
  import rot_scheduler_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] a_data;
  logic [AMT_W-1:0]  a_amt;
  logic              a_sweep;

  logic              b_valid;
  logic              b_ready;
  logic [DATA_W-1:0] b_data;
  logic [AMT_W-1:0]  b_amt;
  logic              b_sweep;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_last;

  modport master (
    output a_valid, a_data, a_amt, a_sweep,
    output b_valid, b_data, b_amt, b_sweep,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_src, out_last
  );

  modport slave (
    input  a_valid, a_data, a_amt, a_sweep,
    input  b_valid, b_data, b_amt, b_sweep,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_src, out_last
  );

endinterface

// File: rtl/barrelshifter.sv
// rtl/barrelshifter.sv - combinational 8-bit rotate-right
// x   : operand
// amt : rotate-right amount 0..7
// y   : x rotated right by amt
module barrelshifter (
  input  logic [7:0] x,
  input  logic [2:0] amt,
  output logic [7:0] y
);

  logic [7:0] s1;
  logic [7:0] s2;

  // Log-depth rotate: stages by 1, 2 and 4.
  always_comb begin
    s1 = amt[0] ? {x[0],    x[7:1]}  : x;
    s2 = amt[1] ? {s1[1:0], s1[7:2]} : s1;
    y  = amt[2] ? {s2[3:0], s2[7:4]} : s2;
  end

endmodule

// File: rtl/rot_scheduler.sv
// rtl/rot_scheduler.sv - two-requester round-robin rotate scheduler with sweep support
// clk : clock, all state on rising edge
// rst : synchronous active-high reset
// bus : rot_scheduler_if.slave (requests A/B in, rotated results out)
// SWEEP_EN : 1 = sweep requests produce 8 results, 0 = sweep behaves as one rotation
module rot_scheduler
  import rot_scheduler_pkg::*;
#(
  parameter bit SWEEP_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  rot_scheduler_if.slave  bus
);

  state_e            state_q, state_d;
  src_e              prio_q, prio_d;      // requester favoured on contention
  logic [DATA_W-1:0] op_q, op_d;
  logic [AMT_W-1:0]  k_q, k_d;            // step for the next result to load
  src_e              src_q, src_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // results still to be loaded
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  src_e              out_src_q, out_src_d;
  logic              out_last_q, out_last_d;

  logic              out_free;
  logic              finishing;
  logic              can_accept;
  src_e              win;
  logic              grant_a, grant_b, accept;
  logic [DATA_W-1:0] cmd_data;
  logic [AMT_W-1:0]  cmd_amt;
  logic              cmd_sweep;
  logic [CNT_W-1:0]  cmd_cnt;
  logic [DATA_W-1:0] sh_x, sh_y;
  logic [AMT_W-1:0]  sh_amt;

  // Arbitration. The cycle in which the final result drains counts as
  // idle so a new command can follow with no bubble.
  always_comb begin
    out_free   = !out_valid_q || bus.out_ready;
    finishing  = out_valid_q && bus.out_ready && out_last_q;
    can_accept = !rst && out_free && ((state_q == IDLE) || finishing);
    if (bus.a_valid && bus.b_valid) win = prio_q;
    else if (bus.b_valid)           win = SRC_B;
    else                            win = SRC_A;
    grant_a   = can_accept && bus.a_valid && (win == SRC_A);
    grant_b   = can_accept && bus.b_valid && (win == SRC_B);
    accept    = grant_a || grant_b;
    cmd_data  = (win == SRC_B) ? bus.b_data  : bus.a_data;
    cmd_amt   = (win == SRC_B) ? bus.b_amt   : bus.a_amt;
    cmd_sweep = (win == SRC_B) ? bus.b_sweep : bus.a_sweep;
    cmd_cnt   = (SWEEP_EN && cmd_sweep) ? SWEEP_CNT : ONE_CNT;
  end

  // The single rotator serves the first result straight from the accepted
  // command and later sweep steps from the held operand.
  assign sh_x   = accept ? cmd_data : op_q;
  assign sh_amt = accept ? cmd_amt  : k_q;

  barrelshifter u_rot (
    .x   (sh_x),
    .amt (sh_amt),
    .y   (sh_y)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    op_d        = op_q;
    k_d         = k_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (finishing)                    state_d     = IDLE;

    if (accept) begin
      state_d     = BUSY;
      prio_d      = (win == SRC_A) ? SRC_B : SRC_A;
      op_d        = cmd_data;
      k_d         = cmd_amt + 1'b1;
      src_d       = win;
      cnt_d       = cmd_cnt - 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = sh_y;
      out_src_d   = win;
      out_last_d  = (cmd_cnt == ONE_CNT);
    end else if ((state_q == BUSY) && out_free && (cnt_q != '0)) begin
      k_d         = k_q + 1'b1;    // wraps 7 -> 0
      cnt_d       = cnt_q - 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = sh_y;
      out_src_d   = src_q;
      out_last_d  = (cnt_q == ONE_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= SRC_A;
      op_q        <= '0;
      k_q         <= '0;
      src_q       <= SRC_A;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_A;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      op_q        <= op_d;
      k_q         <= k_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rot_scheduler.sv
// tb/tb_rot_scheduler.sv - self-checking bench for rot_scheduler against a result-queue model
module tb_rot_scheduler;
  import rot_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rot_scheduler_if intf ();
  rot_scheduler_if intf0 ();

  rot_scheduler #(.SWEEP_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  rot_scheduler #(.SWEEP_EN(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (intf0.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: every accepted command expands into its full list of expected
  // results ({last, src, data}); results leave the queue on each handshake.
  logic [9:0] exp_q[$];
  logic       prio_b;          // 1 when B is favoured on contention
  logic       acc_a, acc_b;
  logic       obs_valid, obs_src, obs_last, obs_a_ready, obs_b_ready;
  logic [7:0] obs_data;

  function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} >> k;
    return t[7:0];
  endfunction

  task automatic model_step();
    int         win;
    int         n;
    logic [7:0] d;
    int         am;
    bit         sw;
    bit         elig;
    logic [9:0] e;
    obs_valid   = intf.out_valid;
    obs_data    = intf.out_data;
    obs_src     = intf.out_src;
    obs_last    = intf.out_last;
    obs_a_ready = intf.a_ready;
    obs_b_ready = intf.b_ready;
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (rst) begin
      check_eq("rst_a_ready", intf.a_ready, 0);
      check_eq("rst_b_ready", intf.b_ready, 0);
      exp_q.delete();
      prio_b = 1'b0;
      return;
    end
    check_eq("out_valid", intf.out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check_eq("out_data", intf.out_data, exp_q[0][7:0]);
      check_eq("out_src",  intf.out_src,  exp_q[0][8]);
      check_eq("out_last", intf.out_last, exp_q[0][9]);
    end
    elig = (exp_q.size() == 0) || (exp_q.size() == 1 && intf.out_ready);
    win = -1;
    if (elig) begin
      if (intf.a_valid && intf.b_valid) win = prio_b ? 1 : 0;
      else if (intf.a_valid)            win = 0;
      else if (intf.b_valid)            win = 1;
    end
    check_eq("a_ready", intf.a_ready, win == 0);
    check_eq("b_ready", intf.b_ready, win == 1);
    if (exp_q.size() > 0 && intf.out_ready) void'(exp_q.pop_front());
    if (win >= 0) begin
      d  = (win == 1) ? intf.b_data  : intf.a_data;
      am = (win == 1) ? int'(intf.b_amt) : int'(intf.a_amt);
      sw = (win == 1) ? intf.b_sweep : intf.a_sweep;
      n  = sw ? 8 : 1;
      for (int i = 0; i < n; i++) begin
        e = {(i == n - 1), (win == 1), rotr(d, (am + i) % 8)};
        exp_q.push_back(e);
      end
      prio_b = (win == 0);
      acc_a  = (win == 0);
      acc_b  = (win == 1);
    end
  endtask

  // One clock: sample/model at the falling edge, return just after the
  // rising edge with accepted requests withdrawn.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (acc_a) intf.a_valid = 1'b0;
    if (acc_b) intf.b_valid = 1'b0;
  endtask

  task automatic set_a(input logic [7:0] d, input logic [2:0] amt, input bit sw);
    intf.a_valid = 1'b1; intf.a_data = d; intf.a_amt = amt; intf.a_sweep = sw;
  endtask

  task automatic set_b(input logic [7:0] d, input logic [2:0] amt, input bit sw);
    intf.b_valid = 1'b1; intf.b_data = d; intf.b_amt = amt; intf.b_sweep = sw;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || intf.a_valid || intf.b_valid) && n < 60) begin
      tick();
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] sw_tab [8];
    logic [7:0] held;
    logic [7:0] d0;
    int         guard;

    sw_tab = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    prio_b = 1'b0;
    intf.a_valid = 0; intf.a_data = 0; intf.a_amt = 0; intf.a_sweep = 0;
    intf.b_valid = 0; intf.b_data = 0; intf.b_amt = 0; intf.b_sweep = 0;
    intf.out_ready = 1'b1;
    intf0.a_valid = 0; intf0.a_data = 0; intf0.a_amt = 0; intf0.a_sweep = 0;
    intf0.b_valid = 0; intf0.b_data = 0; intf0.b_amt = 0; intf0.b_sweep = 0;
    intf0.out_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_out_valid", intf.out_valid, 0);
    check_eq("rst_out_data",  intf.out_data,  0);
    check_eq("rst_out_src",   intf.out_src,   0);
    check_eq("rst_out_last",  intf.out_last,  0);
    rst = 1'b0;
    tick();

    // Single command from A.
    set_a(8'hB4, 3'd3, 1'b0);
    tick();
    check_eq("single_acc", acc_a, 1);
    tick();
    check_eq("single_valid", obs_valid, 1);
    check_eq("single_data",  obs_data,  8'h96);
    check_eq("single_src",   obs_src,   0);
    check_eq("single_last",  obs_last,  1);
    tick();
    check_eq("single_idle", obs_valid, 0);

    // Full sweep from B.
    set_b(8'h01, 3'd0, 1'b1);
    tick();
    check_eq("sweep_acc", acc_b, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("sweep_data%0d", i), obs_data, sw_tab[i]);
      check_eq($sformatf("sweep_last%0d", i), obs_last, i == 7);
      check_eq($sformatf("sweep_src%0d", i),  obs_src,  1);
    end
    tick();
    check_eq("sweep_idle", obs_valid, 0);

    // Contention straight after reset alternates A, B, A, B.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_a(8'($urandom), 3'($urandom), 1'b0);
    set_b(8'($urandom), 3'($urandom), 1'b0);
    for (int g = 0; g < 4; g++) begin
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!acc_a && !acc_b && guard < 10);
      check_eq($sformatf("contend_seen%0d", g),  acc_a | acc_b, 1);
      check_eq($sformatf("contend_grant%0d", g), acc_b, g % 2);
      intf.a_valid = 1'b1;
      intf.b_valid = 1'b1;
    end
    intf.a_valid = 1'b0;
    intf.b_valid = 1'b0;
    drain();

    // Backpressure in the middle of a sweep with B waiting.
    set_a(8'hC3, 3'd6, 1'b1);
    tick();
    tick();
    intf.out_ready = 1'b0;
    set_b(8'($urandom), 3'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) held = obs_data;
      check_eq($sformatf("bp_data%0d", i),  obs_data, held);
      check_eq($sformatf("bp_last%0d", i),  obs_last, 0);
      check_eq($sformatf("bp_ready%0d", i), obs_a_ready | obs_b_ready, 0);
    end
    intf.out_ready = 1'b1;
    drain();

    // Reset after the third sweep result.
    set_b(8'($urandom), 3'($urandom), 1'b1);
    tick();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", intf.out_valid, 0);
    set_a(8'($urandom), 3'($urandom), 1'b0);
    set_b(8'($urandom), 3'($urandom), 1'b0);
    tick();
    check_eq("mid_rst_grant_a", obs_a_ready, 1);
    drain();

    // SWEEP_EN = 0: sweep request yields a single rotation.
    d0 = 8'($urandom);
    intf0.a_valid = 1'b1; intf0.a_data = d0; intf0.a_amt = 3'd5; intf0.a_sweep = 1'b1;
    @(negedge clk);
    check_eq("nosweep_ready", intf0.a_ready, 1);
    @(posedge clk);
    #1;
    intf0.a_valid = 1'b0;
    check_eq("nosweep_valid", intf0.out_valid, 1);
    check_eq("nosweep_data",  intf0.out_data,  rotr(d0, 5));
    check_eq("nosweep_last",  intf0.out_last,  1);
    @(posedge clk);
    #1;
    check_eq("nosweep_done", intf0.out_valid, 0);

    // Randomized traffic with backpressure and occasional reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!intf.a_valid && ($urandom % 3 == 0))
        set_a(8'($urandom), 3'($urandom), ($urandom % 4 == 0));
      if (!intf.b_valid && ($urandom % 3 == 0))
        set_b(8'($urandom), 3'($urandom), ($urandom % 4 == 0));
      intf.out_ready = ($urandom % 4 != 0);
      rst = ($urandom % 250 == 0);
      tick();
    end
    rst = 1'b0;
    intf.a_valid = 1'b0;
    intf.b_valid = 1'b0;
    intf.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rot_scheduler.md
ROT_SCHEDULER -- requirements
Module: rot_scheduler

Interface
REQ-001 Parameter SWEEP_EN, default 1, meaning 1 enables 8-step sweep requests; 0 treats sweep as single rotation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_valid  input  1  requester A has a command.
REQ-005 a_ready  output  1  requester A command accepted this cycle when a_valid high.
REQ-006 a_data  input  8  requester A operand.
REQ-007 a_amt  input  3  requester A rotate-right amount.
REQ-008 a_sweep  input  1  requester A asks for all 8 rotations.
REQ-009 b_valid, b_ready, b_data[8], b_amt[3], b_sweep: same directions and meanings for requester B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_data  output  8  rotated operand.
REQ-013 out_src  output  1  0 = A, 1 = B.
REQ-014 out_last  output  1  final result of the command.

Function
REQ-015 Rotation: result = operand rotated right by k, k = 0..7, i.e. {x[k-1:0], x[7:k]}; k = 0 gives x.
REQ-016 States: IDLE (no command held) and BUSY (command held, results pending).
REQ-017 Handshake: a transfer occurs only when valid and ready are both high in the same cycle; requesters hold valid, data, amt and sweep stable until accepted.
REQ-018 In IDLE, ready goes to at most one requester: the winner of arbitration, provided the output register is empty or drained this cycle (out_valid low or out_ready high).
REQ-019 Arbitration is round-robin. With both valid, the requester not granted last wins; with one valid, that one wins.
REQ-020 The round-robin pointer updates only on an accepted command.
REQ-021 On acceptance, the command latches: operand, amt as step k, source, and remaining count. Count = 8 if sweep and SWEEP_EN = 1, else 1.
REQ-022 The output register loads one cycle after acceptance (latency 1): out_data = rotate(operand, k), out_src = source, out_last = (count = 1).
REQ-023 Each further result loads when the output register is empty or drains (out_valid high and out_ready high) and count > 0 remains. Sweep steps use k+1 modulo 8, wrapping 7 -> 0.
REQ-024 The last output handshake with out_last = 1 returns the block to IDLE. A new command is accepted in that same cycle if eligible (REQ-018), giving back-to-back throughput of one result per cycle.
REQ-025 While out_valid is high and out_ready is low, out_data, out_src and out_last hold stable and no ready is asserted.
REQ-026 a_ready and b_ready are never high in the same cycle; both are low in BUSY.

Reset
REQ-027 While rst is high at a clock edge: state = IDLE, out_valid = 0, out_data = 0, out_src = 0, out_last = 0, count = 0, round-robin pointer favours A.
REQ-028 a_ready and b_ready are 0 during reset.
REQ-029 Reset mid-command discards the command and any unaccepted result, with no further output.

Structure
REQ-030 The shared package holds the state encoding (IDLE, BUSY), the source encoding (SRC_A = 0, SRC_B = 1), and constants DATA_W = 8, AMT_W = 3, SWEEP_STEPS = 8.
REQ-031 Exactly one instance of the existing combinational 8-bit rotate-right block barrelshifter (ports x, amt, y) does all rotation; no other rotate logic exists.
REQ-032 The arbiter, sequencer and output register are in rot_scheduler; no further sub-modules.

Verification
REQ-033 Single command: A sends data 8'hB4, amt 3, sweep 0, out_ready 1 -> one cycle later out_data 8'h96, out_src 0, out_last 1, then IDLE.
REQ-034 Sweep: B sends data 8'h01, amt 0, sweep 1, out_ready 1 -> 8 consecutive results 01, 80, 40, 20, 10, 08, 04, 02, out_src 1, out_last only on 02.
REQ-035 Contention: A and B both valid in the first cycle after reset -> A served first, then B; repeated contention alternates A, B, A, B.
REQ-036 Backpressure: out_ready held low for 5 cycles during a sweep -> out_data, out_last stable, a_ready = b_ready = 0; on release the sequence resumes with no step skipped or repeated.
REQ-037 Reset mid-sweep: rst pulsed after the 3rd result -> next cycle out_valid 0, IDLE. A subsequent contention grants A first.
REQ-038 SWEEP_EN = 0: sweep request with amt 5 -> exactly one result, rotated by 5, with out_last 1.
